// File: rtl/dut_pwr_seq_if.sv
// Host-side command channel of the DUT power sequencer: divider setting
// plus a valid/ready command handshake.
interface dut_pwr_seq_if #(
  parameter int DIV_W = 8
) ();
  logic [DIV_W-1:0] cfg_div;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;

  modport master (
    output cfg_div,
    output cmd_valid,
    output cmd_op,
    input  cmd_ready
  );

  modport slave (
    input  cfg_div,
    input  cmd_valid,
    input  cmd_op,
    output cmd_ready
  );
endinterface

// File: rtl/dut_pwr_seq.sv
// DUT bring-up sequencer: programmable divided DUT clock, timed reset
// release after a fixed number of DUT clock rises, and a clean power-off
// that always lets a high phase finish and parks the clock low before the
// pad output-enable is dropped.
module dut_pwr_seq #(
  parameter int DIV_W     = 8,
  parameter int RST_EDGES = 16
) (
  input  logic         clk,
  input  logic         rst,
  dut_pwr_seq_if.slave cmd_if,
  output logic         dut_clk,
  output logic         dut_rst_n,
  output logic         dut_oe,
  output logic         stat_run
);

  localparam int EDGE_W = $clog2(RST_EDGES + 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(RST_EDGES);

  localparam logic [1:0] OP_NOP         = 2'd0;
  localparam logic [1:0] OP_POWER_ON    = 2'd1;
  localparam logic [1:0] OP_POWER_OFF   = 2'd2;
  localparam logic [1:0] OP_RESET_PULSE = 2'd3;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic [DIV_W-1:0]  div_lat_q,   div_lat_d;
  logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q,  edge_cnt_d;
  logic              dut_clk_q,   dut_clk_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic              dut_oe_q,    dut_oe_d;
  logic              stat_run_q,  stat_run_d;

  logic              cmd_ready;
  logic              cmd_acc;
  logic              div_hit;
  logic [DIV_W-1:0]  div_cnt_step;

  // Commands are only taken in the two steady states.
  assign cmd_ready        = (state_q == S_OFF) | (state_q == S_RUN);
  assign cmd_if.cmd_ready = cmd_ready;
  assign cmd_acc          = cmd_if.cmd_valid & cmd_ready;

  // Equality compare then wrap, so the all-ones setting never overflows.
  assign div_hit      = (div_cnt_q == div_lat_q);
  assign div_cnt_step = div_hit ? {DIV_W{1'b0}} : (div_cnt_q + DIV_W'(1));

  // Next-state decode for the sequencer and all of its outputs.
  always_comb begin
    state_d     = state_q;
    div_lat_d   = div_lat_q;
    div_cnt_d   = div_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    dut_clk_d   = dut_clk_q;
    dut_rst_n_d = dut_rst_n_q;
    dut_oe_d    = dut_oe_q;
    stat_run_d  = stat_run_q;

    case (state_q)
      S_OFF: begin
        if (cmd_acc && (cmd_if.cmd_op == OP_POWER_ON)) begin
          state_d     = S_HOLD;
          div_lat_d   = cmd_if.cfg_div;
          div_cnt_d   = {DIV_W{1'b0}};
          edge_cnt_d  = {EDGE_W{1'b0}};
          dut_clk_d   = 1'b0;
          dut_rst_n_d = 1'b0;
          dut_oe_d    = 1'b1;
          stat_run_d  = 1'b0;
        end else begin
          // Divider idles; other commands are swallowed.
          div_cnt_d = {DIV_W{1'b0}};
        end
      end

      S_HOLD: begin
        div_cnt_d = div_cnt_step;
        if (div_hit) begin
          dut_clk_d = ~dut_clk_q;
          if (!dut_clk_q) begin
            // Rising toggle: count it, saturating at the release count.
            if (edge_cnt_q != EDGE_MAX) begin
              edge_cnt_d = edge_cnt_q + EDGE_W'(1);
            end else begin
              edge_cnt_d = edge_cnt_q;
            end
          end else if (edge_cnt_q == EDGE_MAX) begin
            // Release reset together with the falling DUT clock edge.
            dut_rst_n_d = 1'b1;
            stat_run_d  = 1'b1;
            state_d     = S_RUN;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          dut_clk_d = dut_clk_q;
        end
      end

      S_RUN: begin
        div_cnt_d = div_cnt_step;
        if (div_hit) begin
          dut_clk_d = ~dut_clk_q;
        end else begin
          dut_clk_d = dut_clk_q;
        end
        if (cmd_acc) begin
          case (cmd_if.cmd_op)
            OP_RESET_PULSE: begin
              // Divider phase is untouched; only the reset window restarts.
              state_d     = S_HOLD;
              dut_rst_n_d = 1'b0;
              stat_run_d  = 1'b0;
              edge_cnt_d  = {EDGE_W{1'b0}};
            end
            OP_POWER_OFF: begin
              state_d     = S_STOP;
              dut_rst_n_d = 1'b0;
              stat_run_d  = 1'b0;
            end
            OP_NOP, OP_POWER_ON: begin
              state_d = S_RUN;
            end
            default: begin
              state_d = S_RUN;
            end
          endcase
        end else begin
          state_d = S_RUN;
        end
      end

      S_STOP: begin
        if (!dut_clk_q) begin
          // Clock is parked low: safe to release the pads.
          state_d   = S_OFF;
          dut_oe_d  = 1'b0;
          div_cnt_d = {DIV_W{1'b0}};
        end else begin
          // Finish the high phase; rising toggles are never produced here.
          div_cnt_d = div_cnt_step;
          if (div_hit) begin
            dut_clk_d = 1'b0;
          end else begin
            dut_clk_d = dut_clk_q;
          end
        end
      end

      default: begin
        state_d     = S_OFF;
        div_lat_d   = {DIV_W{1'b0}};
        div_cnt_d   = {DIV_W{1'b0}};
        edge_cnt_d  = {EDGE_W{1'b0}};
        dut_clk_d   = 1'b0;
        dut_rst_n_d = 1'b0;
        dut_oe_d    = 1'b0;
        stat_run_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OFF;
      div_lat_q   <= {DIV_W{1'b0}};
      div_cnt_q   <= {DIV_W{1'b0}};
      edge_cnt_q  <= {EDGE_W{1'b0}};
      dut_clk_q   <= 1'b0;
      dut_rst_n_q <= 1'b0;
      dut_oe_q    <= 1'b0;
      stat_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_lat_q   <= div_lat_d;
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      dut_clk_q   <= dut_clk_d;
      dut_rst_n_q <= dut_rst_n_d;
      dut_oe_q    <= dut_oe_d;
      stat_run_q  <= stat_run_d;
    end
  end

  assign dut_clk   = dut_clk_q;
  assign dut_rst_n = dut_rst_n_q;
  assign dut_oe    = dut_oe_q;
  assign stat_run  = stat_run_q;

endmodule

// File: tb/tb_dut_pwr_seq.sv
// Directed self-checking bench for dut_pwr_seq with RST_EDGES=4.
// Outputs are sampled on the falling clk edge; inputs change right after it.
`timescale 1ns/1ps
module tb_dut_pwr_seq;
  localparam int DIV_W     = 8;
  localparam int RST_EDGES = 4;

  localparam logic [1:0] OP_NOP         = 2'd0;
  localparam logic [1:0] OP_POWER_ON    = 2'd1;
  localparam logic [1:0] OP_POWER_OFF   = 2'd2;
  localparam logic [1:0] OP_RESET_PULSE = 2'd3;

  logic clk;
  logic rst;
  logic dut_clk;
  logic dut_rst_n;
  logic dut_oe;
  logic stat_run;

  int tests_run;
  int tests_failed;

  dut_pwr_seq_if #(.DIV_W(DIV_W)) cmd_if ();

  dut_pwr_seq #(.DIV_W(DIV_W), .RST_EDGES(RST_EDGES)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_if    (cmd_if),
    .dut_clk   (dut_clk),
    .dut_rst_n (dut_rst_n),
    .dut_oe    (dut_oe),
    .stat_run  (stat_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {dut_clk, dut_rst_n, dut_oe, stat_run, cmd_ready}.
  function automatic logic [4:0] outs();
    return {dut_clk, dut_rst_n, dut_oe, stat_run, cmd_if.cmd_ready};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a command for exactly one clk edge; returns at the sample after it.
  task automatic issue(input logic [1:0] op);
    cmd_if.cmd_op    = op;
    cmd_if.cmd_valid = 1'b1;
    cyc();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
  endtask

  task automatic measure_phases(output int hi, output int lo);
    int n;
    n = 0;
    while (dut_clk !== 1'b0 && n < 600) begin cyc(); n++; end
    n = 0;
    while (dut_clk !== 1'b1 && n < 600) begin cyc(); n++; end
    hi = 0;
    while (dut_clk === 1'b1 && hi < 600) begin cyc(); hi++; end
    lo = 0;
    while (dut_clk === 1'b0 && lo < 600) begin cyc(); lo++; end
  endtask

  // POWER_ON with cfg_div=1 from OFF, traced cycle by cycle up to release.
  task automatic power_on_trace(input string name);
    logic [4:0] exp;
    logic       ec;
    logic       er;
    cmd_if.cfg_div = 8'd1;
    issue(OP_POWER_ON);
    for (int k = 1; k <= 17; k++) begin
      ec  = 1'(((k - 1) >> 1) & 1);
      er  = (k == 17);
      exp = {ec, er, 1'b1, er, er};
      tests_run++;
      if (outs() !== exp) begin
        tests_failed++;
        $display("FAIL %s cycle T+%0d: got %b want %b", name, k, outs(), exp);
      end
      if (k < 17) cyc();
    end
  endtask

  task automatic power_on_wait(input logic [7:0] div, input int exp_n, input string name);
    int n;
    cmd_if.cfg_div = div;
    issue(OP_POWER_ON);
    n = 1;
    while (stat_run !== 1'b1 && n < 5000) begin cyc(); n++; end
    tests_run++;
    if (n != exp_n) begin
      tests_failed++;
      $display("FAIL %s_release_time: got T+%0d want T+%0d", name, n, exp_n);
    end
    tests_run++;
    if ({dut_clk, dut_rst_n, dut_oe, cmd_if.cmd_ready} !== 4'b0111) begin
      tests_failed++;
      $display("FAIL %s_release_outs: got %b want %b", name,
               {dut_clk, dut_rst_n, dut_oe, cmd_if.cmd_ready}, 4'b0111);
    end
  endtask

  task automatic power_off_park(input string name);
    int n;
    issue(OP_POWER_OFF);
    n = 0;
    while (dut_oe === 1'b1 && n < 600) begin cyc(); n++; end
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL %s_parked: got %b want %b", name, outs(), 5'b00001);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cfg_div   = 8'd1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL reset_asserted: got %b want %b", outs(), 5'b00001);
    end
    rst = 1'b0;
    cyc();
    cyc();
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL reset_released: got %b want %b", outs(), 5'b00001);
    end
  endtask

  task automatic test_off_cmds();
    issue(OP_POWER_OFF);
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL off_power_off: got %b want %b", outs(), 5'b00001);
    end
    issue(OP_RESET_PULSE);
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL off_reset_pulse: got %b want %b", outs(), 5'b00001);
    end
    repeat (3) cyc();
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL off_idle: got %b want %b", outs(), 5'b00001);
    end
  endtask

  task automatic test_power_on();
    power_on_trace("power_on");
  endtask

  // Entered right at release: dut_clk fell on the previous edge.
  task automatic test_reset_pulse();
    int   i;
    int   last;
    int   rises;
    int   bad;
    logic prev;
    issue(OP_RESET_PULSE);
    tests_run++;
    if (outs() !== 5'b00100) begin
      tests_failed++;
      $display("FAIL pulse_entry: got %b want %b", outs(), 5'b00100);
    end
    i = 0; last = -1; rises = 0; bad = 0;
    while (dut_rst_n !== 1'b1 && i < 64) begin
      prev = dut_clk;
      cyc();
      i++;
      if (dut_clk !== prev) begin
        if (i - last != 2) bad++;
        last = i;
        if (dut_clk === 1'b1) rises++;
      end
    end
    tests_run++;
    if (i != 15) begin
      tests_failed++;
      $display("FAIL pulse_release_time: got T+%0d want T+%0d", i + 1, 16);
    end
    tests_run++;
    if (rises != 4) begin
      tests_failed++;
      $display("FAIL pulse_rises: got %0d want %0d", rises, 4);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL pulse_phase: got %0d bad phases want %0d", bad, 0);
    end
    tests_run++;
    if (outs() !== 5'b01111) begin
      tests_failed++;
      $display("FAIL pulse_release_outs: got %b want %b", outs(), 5'b01111);
    end
  endtask

  task automatic test_ignored_run();
    int hi;
    int lo;
    cmd_if.cfg_div = 8'd5;
    issue(OP_POWER_ON);
    tests_run++;
    if ({dut_rst_n, dut_oe, stat_run, cmd_if.cmd_ready} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL run_power_on: got %b want %b",
               {dut_rst_n, dut_oe, stat_run, cmd_if.cmd_ready}, 4'b1111);
    end
    measure_phases(hi, lo);
    tests_run++;
    if (hi != 2 || lo != 2) begin
      tests_failed++;
      $display("FAIL run_cfg_ignored: got hi=%0d lo=%0d want hi=2 lo=2", hi, lo);
    end
    power_off_park("run_stop");
  endtask

  task automatic test_clean_stop();
    logic [4:0] exp_seq [4];
    int n;
    int bad;
    exp_seq[0] = 5'b10100;
    exp_seq[1] = 5'b10100;
    exp_seq[2] = 5'b00100;
    exp_seq[3] = 5'b00001;
    // Case 1: POWER_OFF two cycles into a 4-cycle high phase.
    power_on_wait(8'd3, 33, "stop_hi");
    n = 0;
    while (dut_clk !== 1'b1 && n < 20) begin cyc(); n++; end
    tests_run++;
    if (n != 4) begin
      tests_failed++;
      $display("FAIL stop_hi_first_rise: got %0d want %0d", n, 4);
    end
    cyc();
    issue(OP_POWER_OFF);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (outs() !== exp_seq[k]) begin
        tests_failed++;
        $display("FAIL stop_hi_step%0d: got %b want %b", k, outs(), exp_seq[k]);
      end
      if (k < 3) cyc();
    end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (outs() !== 5'b00001) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stop_hi_parked: got %0d bad cycles want %0d", bad, 0);
    end
    // Case 2: POWER_OFF while dut_clk is already low.
    power_on_wait(8'd3, 33, "stop_lo");
    issue(OP_POWER_OFF);
    tests_run++;
    if (outs() !== 5'b00100) begin
      tests_failed++;
      $display("FAIL stop_lo_step0: got %b want %b", outs(), 5'b00100);
    end
    cyc();
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL stop_lo_step1: got %b want %b", outs(), 5'b00001);
    end
  endtask

  task automatic test_boundary();
    int hi;
    int lo;
    power_on_wait(8'd0, 9, "div0");
    measure_phases(hi, lo);
    tests_run++;
    if (hi != 1 || lo != 1) begin
      tests_failed++;
      $display("FAIL div0_period: got hi=%0d lo=%0d want hi=1 lo=1", hi, lo);
    end
    power_off_park("div0");
    power_on_wait(8'd255, 2049, "div255");
    measure_phases(hi, lo);
    tests_run++;
    if (hi != 256 || lo != 256) begin
      tests_failed++;
      $display("FAIL div255_period: got hi=%0d lo=%0d want hi=256 lo=256", hi, lo);
    end
    power_off_park("div255");
  endtask

  task automatic test_mid_reset();
    // Reset during HOLD.
    cmd_if.cfg_div = 8'd1;
    issue(OP_POWER_ON);
    repeat (4) cyc();
    tests_run++;
    if (outs() !== 5'b00100) begin
      tests_failed++;
      $display("FAIL hold_pre: got %b want %b", outs(), 5'b00100);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL hold_async_rst: got %b want %b", outs(), 5'b00001);
    end
    @(negedge clk);
    rst = 1'b0;
    power_on_trace("after_hold_rst");
    // Reset during STOP with dut_clk high.
    cyc();
    cyc();
    issue(OP_POWER_OFF);
    tests_run++;
    if (outs() !== 5'b10100) begin
      tests_failed++;
      $display("FAIL stop_pre: got %b want %b", outs(), 5'b10100);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (outs() !== 5'b00001) begin
      tests_failed++;
      $display("FAIL stop_async_rst: got %b want %b", outs(), 5'b00001);
    end
    @(negedge clk);
    rst = 1'b0;
    power_on_trace("after_stop_rst");
    power_off_park("final");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_off_cmds();
    test_power_on();
    test_reset_pulse();
    test_ignored_run();
    test_clean_stop();
    test_boundary();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dut_pwr_seq.md
# dut_pwr_seq

Bring-up sequencer for the device under test, clocked from the PLL clock and system reset produced by the clock/reset manager. It generates a programmable divided clock for the DUT, applies a timed reset release, and gates the clock cleanly on power-off. It also drives an output-enable so the DUT pins stay high-Z while the DUT is off. A host command interface controls it through a valid/ready handshake.

## Interface
Parameters:
- DIV_W, 8, width of the clock divider setting.
- RST_EDGES, 16, number of DUT clock rising edges during which `dut_rst_n` is held low after start or reset pulse. Must be ≥1.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  asynchronous, active-high reset.
- cfg_div  in  DIV_W  DUT clock half-period minus 1, in `clk` cycles.
- cmd_valid  in  1  command present.
- cmd_op  in  2  command: 0 NOP, 1 POWER_ON, 2 POWER_OFF, 3 RESET_PULSE.
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready` at a rising `clk` edge.
- dut_clk  out  1  divided DUT clock, registered.
- dut_rst_n  out  1  DUT reset, active low, registered.
- dut_oe  out  1  pad output enable for `dut_clk`/`dut_rst_n`, registered.
- stat_run  out  1  high in RUN state.

## Operation
- States: OFF, HOLD, RUN, STOP.
- Reset values: state OFF, `dut_clk`=0, `dut_rst_n`=0, `dut_oe`=0, `stat_run`=0, divider count 0, edge count 0.
- `cmd_ready` = (state==OFF) | (state==RUN), combinational from state. It is 1 out of reset.
- Divider: `div_lat` is latched from `cfg_div` only on POWER_ON acceptance. `cfg_div` changes at any other time are ignored. When the counter equals `div_lat`, the counter returns to 0 and `dut_clk` toggles. Otherwise the counter increments. DUT period = 2·(div_lat+1) `clk` cycles.
- OFF: the divider is idle. POWER_ON moves to HOLD, with `dut_oe`=1, `dut_rst_n`=0, `dut_clk`=0, counters cleared. NOP, POWER_OFF and RESET_PULSE are accepted and have no effect.
- HOLD: the divider runs. Each 0→1 toggle increments the edge count, which saturates at RST_EDGES. On the first 1→0 toggle with edge count == RST_EDGES:
  - `dut_rst_n`←1, in the same cycle that `dut_clk`←0.
  - State moves to RUN.
- RUN: `stat_run`=1.
  - RESET_PULSE: next cycle HOLD, `dut_rst_n`=0, edge count cleared. The divider keeps its phase.
  - POWER_OFF: next cycle STOP, `dut_rst_n`=0.
  - POWER_ON and NOP: no effect.
- STOP: 1→0 toggles are allowed and 0→1 toggles are suppressed.
  - Whenever `dut_clk`==0 the next state is OFF, with `dut_oe`=0 and divider count cleared.
  - So `dut_clk` is never truncated while high and always parks low.
- Async `rst` at any time, including mid-HOLD or mid-STOP, forces all reset values immediately. No glitch requirement applies on `dut_clk` during `rst` assertion.

## Timing
- POWER_ON accepted at edge T:
  - `dut_oe`=1 from T+1.
  - First `dut_clk` rise at T+1+(div_lat+1).
  - `dut_rst_n` rises at T+1+2·RST_EDGES·(div_lat+1), coincident with a `dut_clk` fall.
  - `stat_run` rises in that same cycle.
- RESET_PULSE accepted at T: `dut_rst_n`=0 at T+1. Release follows at the (RST_EDGES)th subsequent falling toggle after RST_EDGES counted rises.
- POWER_OFF accepted at T:
  - `dut_rst_n`=0 and `stat_run`=0 at T+1.
  - The state reaches OFF at most div_lat+2 cycles after T+1.
  - `dut_oe`=0 one cycle after STOP observes `dut_clk`==0.
- All outputs are registered. `dut_clk` never has a high or low phase shorter than div_lat+1 cycles, except through async `rst`.
- div_lat=0 gives a 2-cycle DUT period. div_lat=2^DIV_W−1 must work without counter overflow.

## Test plan
- Reset check: with `rst`=1, all outputs read 0 except `cmd_ready`=1. After deassertion, outputs are unchanged and `cmd_ready`=1.
- Power-on, RST_EDGES=4, `cfg_div`=1, POWER_ON at T:
  - `dut_clk` period is 4.
  - `dut_rst_n` rises at T+17, with `dut_clk` falling the same cycle.
  - `stat_run`=1 at T+17.
  - `cmd_ready` is 0 from T+1 to T+16.
- Reset pulse: in RUN, issue RESET_PULSE at T. Expect `dut_rst_n`=0 at T+1 and exactly 4 `dut_clk` rises before release, with no clock phase disturbance.
- Clean stop: with `cfg_div`=3, issue POWER_OFF while `dut_clk`=1, two cycles after its rise.
  - The high phase completes at 4 cycles.
  - `dut_clk` stays 0 afterwards.
  - `dut_oe`=0 one cycle later.
  - Repeat with `dut_clk`=0 at the time of POWER_OFF and check the same parked-low result.
- Ignored commands and config:
  - POWER_OFF and RESET_PULSE in OFF leave outputs unchanged.
  - Changing `cfg_div` from 1 to 5 during RUN keeps the period at 4.
  - POWER_ON in RUN has no effect.
- Mid-sequence reset: assert `rst` for 1 cycle during HOLD and during STOP. Outputs return to reset values asynchronously, and a subsequent POWER_ON sequence times exactly as in the power-on scenario.
